// File: rtl/ee201_btn_debouncer_pkg.sv
// Shared state codes and sizing helper for the pushbutton debouncer.
// The codes are also decoded by the board-level LED/SSD display logic.
package ee201_btn_debouncer_pkg;

  localparam logic [2:0] QDB_INI  = 3'b000;
  localparam logic [2:0] QDB_WQ   = 3'b001;
  localparam logic [2:0] QDB_SCEN = 3'b010;
  localparam logic [2:0] QDB_HELD = 3'b011;
  localparam logic [2:0] QDB_MCEN = 3'b100;
  localparam logic [2:0] QDB_WR   = 3'b101;

  // Counter width: one spare bit above what the larger terminal count needs.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

  // Debounced level is high in every state that follows an accepted press.
  function automatic logic level_of(input logic [2:0] q);
    logic lvl;
    case (q)
      QDB_SCEN, QDB_HELD, QDB_MCEN, QDB_WR: lvl = 1'b1;
      default:                              lvl = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/ee201_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, synchronous reset.
module ee201_sync2 (
  input  logic Clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic stage1_r;
  logic stage2_r;

  // Two back-to-back flops; stage1_r is the metastability-settling stage.
  always_ff @(posedge Clk) begin
    if (reset) begin
      stage1_r <= 1'b0;
      stage2_r <= 1'b0;
    end else begin
      stage1_r <= d;
      stage2_r <= stage1_r;
    end
  end

  assign q = stage2_r;

endmodule

// File: rtl/ee201_btn_debouncer.sv
// Pushbutton debouncer: sync, bounce rejection, debounced level, single-clock press pulse.
// Optional auto-repeat pulse on MCEN while held, enabled by defining EE201_AUTO_REPEAT_EN.
module ee201_btn_debouncer
  import ee201_btn_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES   = 8
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       PB,
  output logic       DPB,
  output logic       SCEN,
  output logic       MCEN,
  output logic [2:0] q_state
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef EE201_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             pb_s;
  logic [2:0]       state_r;
  logic [2:0]       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;

  ee201_sync2 u_sync (
    .Clk   (Clk),
    .reset (reset),
    .d     (PB),
    .q     (pb_s)
  );

  // Next-state and counter logic; cnt is compared before increment so it never wraps.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      QDB_INI: begin
        if (pb_s) begin
          state_s = QDB_WQ;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = QDB_INI;
          cnt_s   = cnt_r;
        end
      end
      QDB_WQ: begin
        if (!pb_s) begin
          state_s = QDB_INI;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == DB_LAST) begin
          state_s = QDB_SCEN;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = QDB_WQ;
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      QDB_SCEN: begin
        state_s = QDB_HELD;
        cnt_s   = CNT_ZERO;
      end
      QDB_HELD: begin
        if (!pb_s) begin
          state_s = QDB_WR;
          cnt_s   = CNT_ZERO;
`ifdef EE201_AUTO_REPEAT_EN
        end else if (cnt_r == RP_LAST) begin
          state_s = QDB_MCEN;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = QDB_HELD;
          cnt_s   = cnt_r + CNT_ONE;
        end
`else
        end else begin
          state_s = QDB_HELD;
          cnt_s   = cnt_r;
        end
`endif
      end
      QDB_MCEN: begin
        state_s = QDB_HELD;
        cnt_s   = CNT_ZERO;
      end
      QDB_WR: begin
        // A short release returns to HELD, so bounce on release never re-fires SCEN.
        if (pb_s) begin
          state_s = QDB_HELD;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == DB_LAST) begin
          state_s = QDB_INI;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = QDB_WR;
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = QDB_INI;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_r <= QDB_INI;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  assign q_state = state_r;
  assign DPB     = level_of(state_r);
  assign SCEN    = (state_r == QDB_SCEN);
`ifdef EE201_AUTO_REPEAT_EN
  assign MCEN    = (state_r == QDB_MCEN);
`else
  assign MCEN    = 1'b0;
`endif

endmodule

// File: tb/tb_ee201_btn_debouncer.sv
// Directed bench for ee201_btn_debouncer with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Edge 0 is the first rising edge after the stimulus change.
module tb_ee201_btn_debouncer;

  logic       Clk;
  logic       reset;
  logic       PB;
  logic       DPB;
  logic       SCEN;
  logic       MCEN;
  logic [2:0] q_state;

  int n_checks;
  int n_err;

  ee201_btn_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (8)
  ) dut (
    .Clk     (Clk),
    .reset   (reset),
    .PB      (PB),
    .DPB     (DPB),
    .SCEN    (SCEN),
    .MCEN    (MCEN),
    .q_state (q_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic mcen_expected(input int i);
    logic m;
    m = 1'b0;
`ifdef EE201_AUTO_REPEAT_EN
    m = (i > 6) && (((i - 6) % 9) == 0);
`endif
    return m;
  endfunction

  logic [2:0] qtab [0:7];
  int         scen_cnt;
  int         mcen_cnt;
  int         wq_seen;
  int         mcen_want;

  initial begin
    n_checks = 0;
    n_err    = 0;
    qtab = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b011};
`ifdef EE201_AUTO_REPEAT_EN
    mcen_want = 4;
`else
    mcen_want = 0;
`endif

    // 1. reset held with PB high, then released with PB high
    reset = 1'b1;
    PB    = 1'b1;
    tick();
    tick();
    check("reset_outs", {5'd0, DPB, SCEN, MCEN}, 8'h00);
    check("reset_q", {5'd0, q_state}, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("rst_rel_q[%0d]", i), {5'd0, q_state}, {5'd0, qtab[i]});
      check($sformatf("rst_rel_scen[%0d]", i), {7'd0, SCEN}, {7'd0, (i == 6)});
      check($sformatf("rst_rel_dpb[%0d]", i), {7'd0, DPB}, {7'd0, (i >= 6)});
    end
    PB = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("idle_q", {5'd0, q_state}, 8'h00);
    check("idle_dpb", {7'd0, DPB}, 8'h00);

    // 2. clean press, held 20 cycles
    PB = 1'b1;
    scen_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (SCEN) scen_cnt++;
      check($sformatf("press_scen[%0d]", i), {7'd0, SCEN}, {7'd0, (i == 6)});
      check($sformatf("press_dpb[%0d]", i), {7'd0, DPB}, {7'd0, (i >= 6)});
      check($sformatf("press_mcen[%0d]", i), {7'd0, MCEN}, {7'd0, mcen_expected(i)});
    end
    check("press_scen_count", 8'(scen_cnt), 8'd1);

    // 4. release bounce while held: two low samples then high again
    PB = 1'b0;
    tick();
    check("rb_dpb[0]", {7'd0, DPB}, 8'h01);
    tick();
    check("rb_dpb[1]", {7'd0, DPB}, 8'h01);
    PB = 1'b1;
    for (int i = 2; i < 8; i++) begin
      tick();
      check($sformatf("rb_dpb[%0d]", i), {7'd0, DPB}, 8'h01);
      check($sformatf("rb_scen[%0d]", i), {7'd0, SCEN}, 8'h00);
      check($sformatf("rb_mcen[%0d]", i), {7'd0, MCEN}, 8'h00);
    end
    check("rb_q_held", {5'd0, q_state}, 8'h03);
    PB = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("rel_dpb[%0d]", i), {7'd0, DPB}, {7'd0, (i < 6)});
      check($sformatf("rel_scen[%0d]", i), {7'd0, SCEN}, 8'h00);
    end
    check("rel_q", {5'd0, q_state}, 8'h00);

    // 3. press bounce: 1,1,1,0 repeated
    wq_seen = 0;
    for (int i = 0; i < 40; i++) begin
      PB = ((i % 4) != 3);
      tick();
      if (q_state == 3'b001) wq_seen++;
      check($sformatf("pb_q[%0d]", i), {6'd0, q_state[2:1]}, 8'h00);
      check($sformatf("pb_scen[%0d]", i), {7'd0, SCEN}, 8'h00);
      check($sformatf("pb_dpb[%0d]", i), {7'd0, DPB}, 8'h00);
    end
    check("pb_wq_seen", {7'd0, (wq_seen > 0)}, 8'h01);
    PB = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pb_end_q", {5'd0, q_state}, 8'h00);

    // 5. long hold: auto-repeat pulses every 9 clocks when enabled
    PB = 1'b1;
    mcen_cnt = 0;
    for (int i = 0; i < 47; i++) begin
      tick();
      if (MCEN) mcen_cnt++;
      check($sformatf("hold_scen[%0d]", i), {7'd0, SCEN}, {7'd0, (i == 6)});
      check($sformatf("hold_mcen[%0d]", i), {7'd0, MCEN}, {7'd0, mcen_expected(i)});
    end
    check("hold_mcen_count", 8'(mcen_cnt), 8'(mcen_want));

    // 6. reset pulse while held, button stays pressed
    reset = 1'b1;
    tick();
    check("midrst_dpb", {7'd0, DPB}, 8'h00);
    check("midrst_q", {5'd0, q_state}, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("midrst_q[%0d]", i), {5'd0, q_state}, {5'd0, qtab[i]});
      check($sformatf("midrst_scen[%0d]", i), {7'd0, SCEN}, {7'd0, (i == 6)});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
